// File: rtl/adc_align_seq_if.sv
// ----------------------------------------------------------------------------
// Module : adc_align_seq_if
// Brief  : Wishbone master/slave bundle between the alignment sequencer and
//          one ADC receiver register bank.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface adc_align_seq_if;
   logic        m_cyc;
   logic        m_stb;
   logic        m_we;
   logic [3:0]  m_adr;
   logic [31:0] m_dat_o;
   logic [31:0] m_dat_i;
   logic        m_ack;

   modport master (
      output m_cyc, m_stb, m_we, m_adr, m_dat_o,
      input  m_dat_i, m_ack
   );

   modport slave (
      input  m_cyc, m_stb, m_we, m_adr, m_dat_o,
      output m_dat_i, m_ack
   );
endinterface

`default_nettype wire

// File: rtl/adc_align_seq.sv
// ----------------------------------------------------------------------------
// Module : adc_align_seq
// Brief  : Steps per-line IODELAYs of an ADC receiver until every line reads
//          stable, driving the receiver over a Wishbone master port.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_align_seq #(
   parameter int SETTLE = 64,
   parameter int WINDOW = 1024,
   parameter int MAXTAP = 32,
   parameter int TMO    = 255
) (
   input  wire logic       wb_clk,
   input  wire logic       wb_rst,
   input  wire logic       start,
   output logic            busy,
   output logic            done,
   output logic            fail,
   output logic            tmo_err,
   output logic [8:0]      locked,
   output logic [5:0]      taps,
   output logic            chk_rst,
   output logic            chk_enb,
   adc_align_seq_if.master bus
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_DRST   = 4'd1,
      ST_SRST   = 4'd2,
      ST_BSEN   = 4'd3,
      ST_SETTLE = 4'd4,
      ST_CLRBS  = 4'd5,
      ST_MEAS   = 4'd6,
      ST_READ   = 4'd7,
      ST_EVAL   = 4'd8,
      ST_INC    = 4'd9,
      ST_DONE   = 4'd10,
      ST_FAIL   = 4'd11
   } state_t;

   localparam logic [31:0] C_DRST_VAL = 32'h0000_0400;
   localparam logic [31:0] C_SRST_VAL = 32'h0000_0800;
   localparam logic [31:0] C_BSEN_VAL = 32'h0000_3000;
   localparam logic [31:0] C_INC_VAL  = 32'h0000_3200;
   localparam logic [3:0]  C_REG_CTRL = 4'd0;
   localparam logic [3:0]  C_REG_CLR  = 4'd6;
   localparam logic [3:0]  C_REG_RD0  = 4'd7;
   localparam logic [3:0]  C_LAST_RD  = 4'd8;

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [3:0]  rd_idx, rd_idx_nxt;
   logic        cyc, cyc_nxt;
   logic        we, we_nxt;
   logic [3:0]  adr, adr_nxt;
   logic [31:0] dat, dat_nxt;
   logic        chk_rst_nxt, chk_enb_nxt;
   logic        busy_nxt, done_nxt, fail_nxt, tmo_err_nxt;
   logic [8:0]  locked_nxt;
   logic [5:0]  taps_nxt;

   logic        bus_state;
   logic        acked;
   logic        req_we;
   logic [3:0]  req_adr;
   logic [31:0] req_dat;
   logic [8:0]  line_mask;
   logic        unused_rd_hi;

   assign bus.m_cyc   = cyc;
   assign bus.m_stb   = cyc;
   assign bus.m_we    = we;
   assign bus.m_adr   = adr;
   assign bus.m_dat_o = dat;

   // Upper read bits carry no alignment information.
   assign unused_rd_hi = ^bus.m_dat_i[31:8];

   // Frame line sits at reg 7 but owns the top locked bit.
   assign line_mask = (rd_idx == 4'd0) ? 9'h100 : (9'h001 << (rd_idx - 4'd1));

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rd_idx  <= '0;
         cyc     <= 1'b0;
         we      <= 1'b0;
         adr     <= '0;
         dat     <= '0;
         chk_rst <= 1'b0;
         chk_enb <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
         tmo_err <= 1'b0;
         locked  <= '0;
         taps    <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rd_idx  <= rd_idx_nxt;
         cyc     <= cyc_nxt;
         we      <= we_nxt;
         adr     <= adr_nxt;
         dat     <= dat_nxt;
         chk_rst <= chk_rst_nxt;
         chk_enb <= chk_enb_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         fail    <= fail_nxt;
         tmo_err <= tmo_err_nxt;
         locked  <= locked_nxt;
         taps    <= taps_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rd_idx_nxt  = rd_idx;
      cyc_nxt     = cyc;
      we_nxt      = we;
      adr_nxt     = adr;
      dat_nxt     = dat;
      chk_rst_nxt = chk_rst;
      chk_enb_nxt = chk_enb;
      busy_nxt    = busy;
      done_nxt    = done;
      fail_nxt    = fail;
      tmo_err_nxt = tmo_err;
      locked_nxt  = locked;
      taps_nxt    = taps;
      acked       = 1'b0;
      req_we      = 1'b1;
      req_adr     = C_REG_CTRL;
      req_dat     = '0;

      case (state)
         ST_DRST:  req_dat = C_DRST_VAL;
         ST_SRST:  req_dat = C_SRST_VAL;
         ST_BSEN:  req_dat = C_BSEN_VAL;
         ST_CLRBS: req_adr = C_REG_CLR;
         ST_INC:   req_dat = C_INC_VAL | {23'b0, ~locked};
         ST_READ: begin
            req_we  = 1'b0;
            req_adr = C_REG_RD0 + rd_idx;
         end
         default: ;
      endcase

      bus_state = (state == ST_DRST) || (state == ST_SRST) || (state == ST_BSEN) ||
                  (state == ST_CLRBS) || (state == ST_READ) || (state == ST_INC);

      // Idle bus cycle between accesses doubles as the address/data load slot.
      if (bus_state) begin
         if (!cyc) begin
            cyc_nxt = 1'b1;
            we_nxt  = req_we;
            adr_nxt = req_adr;
            dat_nxt = req_dat;
            cnt_nxt = '0;
         end else if (bus.m_ack) begin
            cyc_nxt = 1'b0;
            acked   = 1'b1;
         end else if (cnt == 32'(TMO - 1)) begin
            cyc_nxt     = 1'b0;
            tmo_err_nxt = 1'b1;
            fail_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = ST_FAIL;
         end else begin
            cnt_nxt = cnt + 32'd1;
         end
      end

      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               done_nxt    = 1'b0;
               fail_nxt    = 1'b0;
               tmo_err_nxt = 1'b0;
               locked_nxt  = '0;
               taps_nxt    = '0;
               busy_nxt    = 1'b1;
               state_nxt   = ST_DRST;
            end
         end
         ST_DRST: if (acked) state_nxt = ST_SRST;
         ST_SRST: if (acked) state_nxt = ST_BSEN;
         ST_BSEN: begin
            if (acked) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt == 32'(SETTLE - 1)) begin
               state_nxt = ST_CLRBS;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         ST_CLRBS: begin
            if (acked) begin
               state_nxt   = ST_MEAS;
               chk_rst_nxt = 1'b1;
            end
         end
         ST_MEAS: begin
            if (chk_rst) begin
               chk_rst_nxt = 1'b0;
               chk_enb_nxt = 1'b1;
               cnt_nxt     = '0;
            end else if (cnt == 32'(WINDOW - 1)) begin
               chk_enb_nxt = 1'b0;
               rd_idx_nxt  = '0;
               state_nxt   = ST_READ;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         ST_READ: begin
            if (acked) begin
               if (bus.m_dat_i[7:0] == 8'd0) begin
                  locked_nxt = locked | line_mask;
               end
               if (rd_idx == C_LAST_RD) begin
                  state_nxt = ST_EVAL;
               end else begin
                  rd_idx_nxt = rd_idx + 4'd1;
               end
            end
         end
         ST_EVAL: begin
            if (locked == 9'h1FF) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = ST_DONE;
            end else if (taps == 6'(MAXTAP)) begin
               fail_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = ST_FAIL;
            end else begin
               state_nxt = ST_INC;
            end
         end
         ST_INC: begin
            if (acked) begin
               taps_nxt  = (taps == 6'd63) ? taps : taps + 6'd1;
               cnt_nxt   = '0;
               state_nxt = ST_SETTLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_align_seq.sv
// ----------------------------------------------------------------------------
// Module : tb_adc_align_seq
// Brief  : Directed bench for adc_align_seq with a Wishbone slave model and a
//          queue of expected bus transactions.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_align_seq;
   localparam int SETTLE = 8;
   localparam int WINDOW = 16;
   localparam int MAXTAP = 4;
   localparam int TMO    = 255;
   localparam int LIMIT  = 20000;

   logic       wb_clk = 1'b0;
   logic       wb_rst;
   logic       start;
   logic       busy, done, fail, tmo_err, chk_rst, chk_enb;
   logic [8:0] locked;
   logic [5:0] taps;

   adc_align_seq_if bus();

   adc_align_seq #(
      .SETTLE(SETTLE), .WINDOW(WINDOW), .MAXTAP(MAXTAP), .TMO(TMO)
   ) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start),
      .busy(busy), .done(done), .fail(fail), .tmo_err(tmo_err),
      .locked(locked), .taps(taps),
      .chk_rst(chk_rst), .chk_enb(chk_enb),
      .bus(bus)
   );

   always #5 wb_clk = ~wb_clk;

   typedef struct packed {
      logic        we;
      logic [3:0]  adr;
      logic [31:0] dat;
   } txn_t;

   txn_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   meas_cnt = 0;
   int   line3_bad = 0;
   bit   frame_bad = 1'b0;
   bit   noack_srst = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rd_val(input logic [3:0] a);
      if (a == 4'd7 && frame_bad) return 32'h0000_0055;
      if (a == 4'd11 && meas_cnt <= line3_bad) return 32'hABCD_0001;
      return 32'hFFFF_FF00;
   endfunction

   // Slave: acks each access one cycle after it appears, scoring it on the spot.
   always @(negedge wb_clk) begin
      txn_t e;
      if (bus.m_cyc && bus.m_stb && !bus.m_ack &&
          !(noack_srst && bus.m_we && bus.m_dat_o == 32'h800)) begin
         if (bus.m_we && bus.m_adr == 4'd6) meas_cnt++;
         bus.m_dat_i = rd_val(bus.m_adr);
         bus.m_ack   = 1'b1;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL bus_extra observed we=%0d adr=%0d dat=%0h expected none",
                   bus.m_we, bus.m_adr, bus.m_dat_o);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bus_we_adr", {27'd0, bus.m_we, bus.m_adr}, {27'd0, e.we, e.adr});
            if (e.we) check("bus_wdata", bus.m_dat_o, e.dat);
         end
      end else begin
         bus.m_ack = 1'b0;
      end
   end

   task automatic push_w(input logic [3:0] a, input logic [31:0] d);
      exp_q.push_back('{1'b1, a, d});
   endtask

   task automatic push_init();
      push_w(4'd0, 32'h400);
      push_w(4'd0, 32'h800);
      push_w(4'd0, 32'h3000);
   endtask

   task automatic push_meas();
      push_w(4'd6, 32'h0);
      for (int k = 0; k < 9; k++) exp_q.push_back('{1'b0, 4'(7 + k), 32'h0});
   endtask

   task automatic pulse_start();
      @(negedge wb_clk) start = 1'b1;
      @(negedge wb_clk) start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(done || fail) && n < LIMIT) begin
         @(negedge wb_clk);
         n++;
      end
      check({tag, "_finished"}, 32'(done | fail), 32'd1);
      repeat (2) @(negedge wb_clk);
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_cyc"},    32'(bus.m_cyc),  0);
      check({tag, "_stb"},    32'(bus.m_stb),  0);
      check({tag, "_we"},     32'(bus.m_we),   0);
      check({tag, "_adr"},    32'(bus.m_adr),  0);
      check({tag, "_dat"},    bus.m_dat_o,     0);
      check({tag, "_chk"},    {30'd0, chk_rst, chk_enb}, 0);
      check({tag, "_status"}, {28'd0, busy, done, fail, tmo_err}, 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_taps"},   32'(taps),   0);
   endtask

   initial begin
      int n, r, en, ov;
      bus.m_ack   = 1'b0;
      bus.m_dat_i = '0;
      wb_rst = 1'b1;
      start  = 1'b0;
      repeat (3) @(negedge wb_clk);
      check_cleared("reset");
      wb_rst = 1'b0;

      // Ideal slave, with a second start issued inside the counting window.
      push_init();
      push_meas();
      pulse_start();
      check("s1_busy", 32'(busy), 1);
      n = 0;
      while (!(bus.m_cyc && bus.m_dat_o == 32'h3000) && n < 200) begin
         @(negedge wb_clk); n++;
      end
      check("s1_bsen_seen", 32'(bus.m_dat_o), 32'h3000);
      n = 0;
      while (bus.m_cyc && n < 50) begin @(negedge wb_clk); n++; end
      n = 0;
      while (!bus.m_cyc && n < 200) begin @(negedge wb_clk); n++; end
      check("s1_settle_gap", n, SETTLE + 1);
      n = 0;
      while (!chk_rst && n < 200) begin @(negedge wb_clk); n++; end
      r = 0; en = 0; ov = 0;
      for (int i = 0; i < WINDOW + 20; i++) begin
         if (chk_rst) r++;
         if (chk_enb) en++;
         if (chk_rst && chk_enb) ov++;
         start = (i == 6);
         @(negedge wb_clk);
      end
      start = 1'b0;
      check("s1_chk_rst_cycles", r, 1);
      check("s1_chk_enb_cycles", en, WINDOW);
      check("s1_chk_overlap", ov, 0);
      wait_end("s1");
      check("s1_done", {29'd0, done, fail, tmo_err}, 32'b100);
      check("s1_taps", 32'(taps), 0);
      check("s1_locked", 32'(locked), 32'h1FF);
      check("s1_busy_end", 32'(busy), 0);

      // Line 3 unstable for three measurements.
      meas_cnt = 0; line3_bad = 3;
      push_init();
      for (int m = 1; m <= 4; m++) begin
         push_meas();
         if (m <= 3) push_w(4'd0, 32'h3208);
      end
      pulse_start();
      check("s2_done_cleared", {30'd0, busy, done}, 32'b10);
      wait_end("s2");
      check("s2_done", {29'd0, done, fail, tmo_err}, 32'b100);
      check("s2_taps", 32'(taps), 3);
      check("s2_locked", 32'(locked), 32'h1FF);

      // Frame never stable: gives up once MAXTAP steps are spent.
      meas_cnt = 0; line3_bad = 0; frame_bad = 1'b1;
      push_init();
      for (int m = 1; m <= MAXTAP + 1; m++) begin
         push_meas();
         if (m <= MAXTAP) push_w(4'd0, 32'h3300);
      end
      pulse_start();
      wait_end("s3");
      check("s3_fail", {29'd0, done, fail, tmo_err}, 32'b010);
      check("s3_taps", 32'(taps), MAXTAP);
      check("s3_locked", 32'(locked), 32'h0FF);
      check("s3_busy", 32'(busy), 0);

      // SRST write never acknowledged.
      frame_bad = 1'b0; noack_srst = 1'b1;
      push_w(4'd0, 32'h400);
      pulse_start();
      n = 0;
      while (!(bus.m_cyc && bus.m_dat_o == 32'h800) && n < 200) begin
         @(negedge wb_clk); n++;
      end
      n = 0;
      while (bus.m_cyc && n < 1000) begin @(negedge wb_clk); n++; end
      check("s4_cyc_high_cycles", n, TMO);
      @(negedge wb_clk);
      check("s4_status", {28'd0, busy, done, fail, tmo_err}, 32'b0011);
      check("s4_queue_left", 32'(exp_q.size()), 0);
      noack_srst = 1'b0;

      // Reset during a read access, with start held high through the reset.
      meas_cnt = 0;
      push_init();
      push_meas();
      pulse_start();
      n = 0;
      while (!(bus.m_cyc && !bus.m_we) && n < 500) begin @(negedge wb_clk); n++; end
      check("s5_read_seen", {31'd0, bus.m_cyc & ~bus.m_we}, 1);
      wb_rst = 1'b1;
      start  = 1'b1;
      @(negedge wb_clk);
      check_cleared("s5_after_rst");
      wb_rst = 1'b0;
      start  = 1'b0;
      exp_q.delete();
      repeat (5) @(negedge wb_clk);
      check("s5_idle", {30'd0, bus.m_cyc, busy}, 0);
      meas_cnt = 0;
      push_init();
      push_meas();
      pulse_start();
      wait_end("s5");
      check("s5_done", {29'd0, done, fail, tmo_err}, 32'b100);
      check("s5_locked", 32'(locked), 32'h1FF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/adc_align_seq.md
ADC_ALIGN_SEQ -- requirements
Module: adc_align_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 64: wb_clk cycles waited after each delay change before measuring.
REQ-002 SHALL have parameter WINDOW, default 1024: wb_clk cycles chk_enb is held high per measurement.
REQ-003 SHALL have parameter MAXTAP, default 32: maximum IODELAY increment steps before failure.
REQ-004 SHALL have parameter TMO, default 255: wb_clk cycles allowed for m_ack before a bus timeout.
REQ-005 SHALL have ports: wb_clk in 1, the only clock; wb_rst in 1, reset, synchronous and active-high.
REQ-006 SHALL have ports: start in 1, begin alignment (single-cycle pulse); busy out 1; done out 1, sticky success; fail out 1, sticky failure; tmo_err out 1, sticky bus timeout.
REQ-007 SHALL have ports: locked out 9, per line (bit 8 frame, 7-0 data) stable flag; taps out 6, increment steps issued.
REQ-008 SHALL have ports: m_cyc, m_stb, m_we out 1; m_adr out 4; m_dat_o out 32; m_dat_i in 32; m_ack in 1; these form the Wishbone master to one ADC receiver register bank.
REQ-009 SHALL have ports: chk_rst out 1, error/instability counter reset; chk_enb out 1, counting window.

Function
REQ-010 SHALL implement states IDLE, DRST, SRST, BSEN, SETTLE, CLRBS, MEAS, READ, EVAL, INC, DONE, FAIL.
REQ-011 SHALL, in IDLE/DONE/FAIL, on start=1: clear done, fail, tmo_err, locked, taps; set busy; go to DRST. start while busy is ignored.
REQ-012 SHALL issue writes: DRST writes reg 0 = 0x0000_0400; SRST writes reg 0 = 0x0000_0800; BSEN writes reg 0 = 0x0000_3000; CLRBS writes reg 6 = 0; each advances on ack (DRST->SRST->BSEN->SETTLE, CLRBS->MEAS).
REQ-013 SHALL run each bus cycle as: m_cyc=m_stb=1 with m_adr/m_we/m_dat_o stable until the cycle m_ack=1 is sampled; then drop m_cyc/m_stb for at least one cycle before the next access.
REQ-014 SHALL count wait cycles per access; if m_ack not seen within TMO cycles, drop m_cyc/m_stb, set tmo_err and fail, go to FAIL.
REQ-015 SHALL, in SETTLE, wait exactly SETTLE cycles, then go to CLRBS.
REQ-016 SHALL, in MEAS, assert chk_rst for exactly 1 cycle, then chk_enb for exactly WINDOW cycles (chk_rst and chk_enb never both high), then go to READ.
REQ-017 SHALL, in READ, read regs 7 through 15 in ascending order (m_we=0); for reg 7+k, line index k maps to locked bit 8 for k=0 and bit k-1 for k=1..8.
REQ-018 SHALL set a locked bit when the read m_dat_i[7:0] equals 0; a set locked bit is never cleared until the next start or reset; bits 31-8 of read data are ignored.
REQ-019 SHALL, in EVAL: if locked == 9'h1FF go to DONE; else if taps == MAXTAP go to FAIL; else go to INC.
REQ-020 SHALL, in INC, write reg 0 = 0x3200 | {23'b0, ~locked}, so only unlocked lines step; increment taps (saturating at 63) on ack; go to SETTLE.
REQ-021 SHALL, in DONE, set done; in FAIL, set fail; in both, clear busy and hold all outputs until start or reset.
REQ-022 SHALL keep taps width arithmetic unsigned 6-bit; MAXTAP > 63 is illegal.
REQ-023 SHALL treat all-lines-stable at the first measurement as success with taps = 0 and no INC write.

Reset
REQ-024 SHALL, with wb_rst=1 at a clock edge, go to IDLE and drive: m_cyc=m_stb=m_we=0, m_adr=0, m_dat_o=0, chk_rst=0, chk_enb=0, busy=0, done=0, fail=0, tmo_err=0, locked=0, taps=0.
REQ-025 SHALL abort any bus cycle in progress on reset, dropping m_cyc/m_stb in the cycle after the reset edge.
REQ-026 SHALL ignore start in the cycle where wb_rst=1.

Verification
REQ-027 Ideal slave acks in 1 cycle, all instability reads 0 -> writes 0x400, 0x800, 0x3000 to reg 0, write to reg 6, 9 reads; done=1, taps=0, locked=0x1FF, no INC write.
REQ-028 Slave reports line 3 (reg 11) nonzero for 3 measurements then 0 -> three INC writes of 0x3208; taps=3; done=1.
REQ-029 Frame (reg 7) always nonzero, MAXTAP=4 -> four INC writes with bit 8 set, then fail=1, done=0, taps=4, locked=0x0FF.
REQ-030 Slave never acks the SRST write, TMO=255 -> m_cyc drops after 255 wait cycles; tmo_err=1, fail=1, busy=0.
REQ-031 wb_rst asserted during READ with m_cyc=1 -> next cycle m_cyc=0, state IDLE, all status 0; later start runs full sequence from DRST.
REQ-032 start pulsed again during MEAS -> ignored; chk_enb high exactly WINDOW cycles, preceded by exactly one chk_rst cycle.
